data_out_merge: RTL and testbench

Return-path operator that merges two 32-bit framed streams into a single stream toward a leaf interface's user input port. It is the inverse of the input redirector: frames that were split across two output streams are recombined onto one stream, atomically per frame, with round-robin fairness. It sits between two upstream operators (or two leaf-interface output ports) and one `din_leaf_user2interface` port.

---
 rtl/data_out_merge_pkg.sv | 15 +
 rtl/axis_skid_buf.sv | 58 +++++
 rtl/data_out_merge.sv | 143 ++++++++++++++
 tb/tb_data_out_merge.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_out_merge_pkg.sv
// Shared types and constants for the two-stream frame merger.
// The header length field sits in the low bits of the header word.
package data_out_merge_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_LEN_W   = 16;
    localparam int HDR_LEN_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } state_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered stream buffer. The upstream ready (not_full) depends only
// on the registered occupancy, so it has no combinational path from out_ready.
module axis_skid_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              not_full,
    output logic              empty,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [DATA_W-1:0] mem_reg [2];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        count_reg;
    logic              push;
    logic              pop;

    assign not_full  = (count_reg != 2'd2);
    assign empty     = (count_reg == 2'd0);
    assign out_valid = !empty;
    assign out_data  = mem_reg[rd_ptr_reg];
    assign push      = in_valid && not_full;
    assign pop       = out_valid && out_ready;

    // Entries are cleared on reset so the output data reads zero after reset.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (reset) begin
                mem_reg[gi] <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                mem_reg[gi] <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/data_out_merge.sv
// Merges two framed streams onto one output, one whole frame at a time,
// alternating between inputs whenever both have a frame waiting.
module data_out_merge
    import data_out_merge_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ap_start,
    output logic              ap_idle,
    input  logic [DATA_W-1:0] Input_1_V_TDATA,
    input  logic              Input_1_V_TVALID,
    output logic              Input_1_V_TREADY,
    input  logic [DATA_W-1:0] Input_2_V_TDATA,
    input  logic              Input_2_V_TVALID,
    output logic              Input_2_V_TREADY,
    output logic [DATA_W-1:0] Output_1_V_TDATA,
    output logic              Output_1_V_TVALID,
    input  logic              Output_1_V_TREADY,
    output logic [15:0]       frame_cnt_1,
    output logic [15:0]       frame_cnt_2
);

    state_t             state_reg, state_next;
    logic               grant_reg, grant_next;
    logic               rr_ptr_reg, rr_ptr_next;
    logic [LEN_W-1:0]   remaining_reg, remaining_next;
    logic [15:0]        frame_cnt_reg [2];

    logic [1:0]         in_valid;
    logic [DATA_W-1:0]  in_data [2];
    logic [1:0]         in_ready;
    logic [DATA_W-1:0]  sel_data;
    logic [LEN_W-1:0]   hdr_len;
    logic               xfer;
    logic               frame_done;
    logic               buf_not_full;
    logic               buf_empty;

    assign in_valid = {Input_2_V_TVALID, Input_1_V_TVALID};
    assign in_data[0] = Input_1_V_TDATA;
    assign in_data[1] = Input_2_V_TDATA;
    assign sel_data = in_data[grant_reg];
    assign hdr_len  = sel_data[HDR_LEN_LSB +: LEN_W];

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        rr_ptr_next    = rr_ptr_reg;
        remaining_next = remaining_reg;
        in_ready       = 2'b00;
        xfer           = 1'b0;
        frame_done     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Search starts at rr_ptr; the other input only wins if rr_ptr's input is idle.
                if (ap_start && (in_valid != 2'b00)) begin
                    grant_next = in_valid[rr_ptr_reg] ? rr_ptr_reg : ~rr_ptr_reg;
                    state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                in_ready[grant_reg] = buf_not_full;
                xfer = in_valid[grant_reg] && buf_not_full;
                if (xfer) begin
                    remaining_next = hdr_len;
                    if (hdr_len == '0) begin
                        frame_done = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                in_ready[grant_reg] = buf_not_full;
                xfer = in_valid[grant_reg] && buf_not_full;
                if (xfer) begin
                    remaining_next = remaining_reg - LEN_W'(1);
                    if (remaining_reg == LEN_W'(1)) begin
                        frame_done = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (frame_done) begin
            rr_ptr_next = ~grant_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= 1'b0;
            rr_ptr_reg    <= 1'b0;
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            rr_ptr_reg    <= rr_ptr_next;
            remaining_reg <= remaining_next;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_frame_cnt
        always_ff @(posedge clk) begin
            if (reset) begin
                frame_cnt_reg[gi] <= 16'd0;
            end else if (frame_done && (grant_reg == 1'(gi))) begin
                frame_cnt_reg[gi] <= frame_cnt_reg[gi] + 16'd1;
            end
        end
    end

    axis_skid_buf #(
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .in_data   (sel_data),
        .in_valid  (xfer),
        .not_full  (buf_not_full),
        .empty     (buf_empty),
        .out_data  (Output_1_V_TDATA),
        .out_valid (Output_1_V_TVALID),
        .out_ready (Output_1_V_TREADY)
    );

    assign Input_1_V_TREADY = in_ready[0];
    assign Input_2_V_TREADY = in_ready[1];
    assign frame_cnt_1      = frame_cnt_reg[0];
    assign frame_cnt_2      = frame_cnt_reg[1];
    assign ap_idle          = (state_reg == ST_IDLE) && buf_empty;

endmodule

// File: tb/tb_data_out_merge.sv
// Bench for data_out_merge: queued source frames, a frame-level arbitration model
// producing the expected output word order, and per-word output checking.
module tb_data_out_merge;

    logic        clk = 1'b0;
    logic        reset;
    logic        ap_start;
    logic        ap_idle;
    logic [31:0] in1_data, in2_data;
    logic        in1_valid, in2_valid;
    logic        in1_ready, in2_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] frame_cnt_1, frame_cnt_2;

    always #5 clk = ~clk;

    data_out_merge dut (
        .clk               (clk),
        .reset             (reset),
        .ap_start          (ap_start),
        .ap_idle           (ap_idle),
        .Input_1_V_TDATA   (in1_data),
        .Input_1_V_TVALID  (in1_valid),
        .Input_1_V_TREADY  (in1_ready),
        .Input_2_V_TDATA   (in2_data),
        .Input_2_V_TVALID  (in2_valid),
        .Input_2_V_TREADY  (in2_ready),
        .Output_1_V_TDATA  (out_data),
        .Output_1_V_TVALID (out_valid),
        .Output_1_V_TREADY (out_ready),
        .frame_cnt_1       (frame_cnt_1),
        .frame_cnt_2       (frame_cnt_2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] src1_q[$];
    logic [31:0] src2_q[$];
    logic [31:0] exp_q[$];
    int          in_cyc_q[$];
    int          mcnt[2];
    bit          model_rr;

    int cycle = 0;
    int occ = 0;
    int nf1 = 0, nf2 = 0;
    int last2 = -1;
    int n_out = 0;
    int or_mode = 0;
    bit lat_en = 1'b1;
    bit bp_chk = 1'b0;
    bit zl_chk = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_word(input bit src, input logic [31:0] w);
        if (src) src2_q.push_back(w);
        else     src1_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic gen_frame(input bit src, input logic [15:0] hi, input int len,
                             input bit rnd, input int seq);
        push_word(src, {hi, 16'(len)});
        for (int i = 0; i < len; i++) begin
            if (rnd) push_word(src, $urandom);
            else     push_word(src, (src ? 32'h200 : 32'h100) + 32'(seq * 8 + i));
        end
        mcnt[src]++;
    endtask

    // Frame-level arbitration: whichever input rr points at goes next if it has a frame.
    task automatic run_pair(input int n1, input int n2, input int len,
                            input logic [15:0] hi1, input logic [15:0] hi2, input bit rnd);
        int left[2];
        int seq[2];
        bit pick;
        int l;
        left[0] = n1; left[1] = n2; seq[0] = 0; seq[1] = 0;
        while (left[0] + left[1] > 0) begin
            pick = (left[model_rr] > 0) ? model_rr : ~model_rr;
            l = (len < 0) ? int'($urandom_range(0, 7)) : len;
            gen_frame(pick, pick ? hi2 : hi1, l, rnd, seq[pick]);
            seq[pick]++;
            left[pick]--;
            model_rr = ~pick;
        end
    endtask

    task automatic clear_model();
        src1_q.delete(); src2_q.delete(); exp_q.delete();
        mcnt[0] = 0; mcnt[1] = 0; model_rr = 1'b0;
        nf1 = 0; nf2 = 0; last2 = -1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        clear_model();
        tick(1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_ready", {30'b0, in1_ready, in2_ready}, 32'd0);
        tick(n - 1);
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || src1_q.size() != 0 || src2_q.size() != 0) && k < 3000) begin
            tick(1);
            k++;
        end
        check({tag, "_timeout"}, 32'(k >= 3000), 32'd0);
        tick(2);
        check({tag, "_cnt1"}, {16'b0, frame_cnt_1}, 32'(mcnt[0]));
        check({tag, "_cnt2"}, {16'b0, frame_cnt_2}, 32'(mcnt[1]));
    endtask

    // Source drivers and output monitor, sampled on the falling edge.
    initial begin
        bit f1, f2, fo;
        logic [31:0] e;
        int ic;
        in1_valid = 1'b0; in2_valid = 1'b0; in1_data = '0; in2_data = '0; out_ready = 1'b1;
        forever begin
            @(negedge clk);
            cycle++;
            f1 = in1_valid && in1_ready;
            f2 = in2_valid && in2_ready;
            fo = out_valid && out_ready;
            if (reset) begin
                occ = 0;
                in_cyc_q.delete();
            end else begin
                check("ready_excl", {31'b0, in1_ready & in2_ready}, 32'd0);
                if (bp_chk && nf1 > 0 && src1_q.size() > 0)
                    check("bp_ready_vs_occ", {31'b0, in1_ready}, 32'(occ < 2));
                if (f2 && zl_chk && last2 >= 0)
                    check("zl_gap", 32'(cycle - last2), 32'd2);
                if (f1 || f2) in_cyc_q.push_back(cycle);
                if (f1) nf1++;
                if (f2) begin nf2++; last2 = cycle; end
                if (fo) begin
                    if (exp_q.size() == 0) begin
                        check("extra_word", {31'b0, fo}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_word", out_data, e);
                        $display("out word %0d: 0x%08h", n_out, out_data);
                        n_out++;
                    end
                    if (in_cyc_q.size() != 0) begin
                        ic = in_cyc_q.pop_front();
                        if (lat_en) check("latency", 32'(cycle), 32'(ic + 1));
                    end
                end
                occ = occ + int'(f1 || f2) - int'(fo);
            end
            @(posedge clk);
            #1;
            if (f1 && src1_q.size() != 0) void'(src1_q.pop_front());
            if (f2 && src2_q.size() != 0) void'(src2_q.pop_front());
            in1_valid = (src1_q.size() != 0);
            in1_data  = in1_valid ? src1_q[0] : '0;
            in2_valid = (src2_q.size() != 0);
            in2_data  = in2_valid ? src2_q[0] : '0;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        int k;
        int base;
        reset = 1'b1;
        ap_start = 1'b1;
        clear_model();

        // Reset held three cycles with both inputs presenting 0x0000_0002 headers.
        run_pair(1, 1, 2, 16'h0000, 16'h0000, 1'b0);
        tick(1);
        check("rst_ready1", {31'b0, in1_ready}, 32'd0);
        check("rst_ready2", {31'b0, in2_ready}, 32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_cnt", {frame_cnt_2, frame_cnt_1}, 32'd0);
        check("rst_idle", {31'b0, ap_idle}, 32'd1);
        tick(2);
        check("rst_ready_late", {30'b0, in1_ready, in2_ready}, 32'd0);
        reset = 1'b0;
        tick(1);
        check("first_grant_r1", {31'b0, in1_ready}, 32'd1);
        check("first_grant_r2", {31'b0, in2_ready}, 32'd0);
        drain("rst_default");

        // Single frame on input 1.
        do_reset(2);
        push_word(1'b0, 32'hAAAA_0003);
        for (int i = 1; i <= 3; i++) push_word(1'b0, 32'(i));
        mcnt[0]++;
        drain("single");

        // Fair interleave, five L=2 frames per input.
        do_reset(2);
        run_pair(5, 5, 2, 16'h1000, 16'h2000, 1'b0);
        drain("interleave");
        check("interleave_cnt", {frame_cnt_2, frame_cnt_1}, {16'd5, 16'd5});

        // Zero-length frames on input 2.
        do_reset(2);
        zl_chk = 1'b1;
        run_pair(0, 3, 0, 16'h0000, 16'h5555, 1'b0);
        drain("zero_len");
        zl_chk = 1'b0;

        // Backpressure with toggling downstream ready during an L=8 frame.
        do_reset(2);
        lat_en = 1'b0; bp_chk = 1'b1; or_mode = 1;
        run_pair(1, 0, 8, 16'hB0B0, 16'h0000, 1'b1);
        drain("backpressure");
        bp_chk = 1'b0; or_mode = 0;

        // Mid-frame reset after three of six payload words.
        do_reset(2);
        lat_en = 1'b1;
        run_pair(1, 0, 6, 16'h6666, 16'h0000, 1'b0);
        k = 0;
        while (nf1 < 4 && k < 200) begin tick(1); k++; end
        check("midrst_wait", 32'(nf1 >= 4), 32'd1);
        do_reset(2);
        check("midrst_cleared", {31'b0, out_valid}, 32'd0);
        run_pair(0, 1, 3, 16'h0000, 16'h7777, 1'b1);
        drain("after_midrst");

        // ap_start low in IDLE: nothing is granted.
        ap_start = 1'b0;
        run_pair(0, 1, 2, 16'h0000, 16'h8888, 1'b1);
        tick(5);
        check("gate_ready2", {31'b0, in2_ready}, 32'd0);
        check("gate_idle", {31'b0, ap_idle}, 32'd1);
        check("gate_valid", {31'b0, out_valid}, 32'd0);
        ap_start = 1'b1;
        drain("gate");

        // ap_start dropped right after the header transfer; frame still completes.
        base = nf1;
        run_pair(1, 0, 5, 16'h9999, 16'h0000, 1'b1);
        k = 0;
        while (nf1 == base && k < 200) begin tick(1); k++; end
        ap_start = 1'b0;
        drain("start_drop");
        check("start_drop_idle", {31'b0, ap_idle}, 32'd1);
        ap_start = 1'b1;

        // Randomized rounds with random lengths, data and downstream stalls.
        do_reset(2);
        lat_en = 1'b0; or_mode = 2;
        for (int r = 0; r < 6; r++) begin
            run_pair(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), -1,
                     16'($urandom), 16'($urandom), 1'b1);
            drain("random");
        end
        or_mode = 0;
        tick(2);
        check("final_idle", {31'b0, ap_idle}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
